// File: rtl/pwm_timer_ctrl.sv
// pwm_timer_ctrl: shadow registers, ON/period down-counters and
// prescaler for one PWM channel, plus its register bus slave.
module pwm_timer_ctrl #(
  parameter int WIDTH    = 16,
  parameter int PRESCALE = 1,
  parameter int PWM_UNIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_strobe,
  input  logic        rd_strobe,
  input  logic [1:0]  reg_addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        ack,
  input  logic        dec_T_on,
  input  logic        dec_T_period,
  input  logic        reload_times,
  output logic        pwm_enable,
  output logic        T_on_zero,
  output logic        T_period_zero,
  output logic        period_done
);

  localparam logic [15:0] LP_LAST = 16'(PRESCALE - 1);

  logic [WIDTH-1:0] r_period;
  logic [WIDTH-1:0] r_on;
  logic             r_en;
  logic [15:0]      r_count;
  logic             r_pwm_enable;
  logic             r_ack;
  logic [31:0]      r_rd_data;
  logic             r_period_done;
  logic [15:0]      r_presc;
  logic [WIDTH-1:0] r_t_on;
  logic [WIDTH-1:0] r_t_period;

  logic             w_tick;
  logic             w_clr;
  logic [WIDTH-1:0] w_on_ld;
  logic [31:0]      w_rd_mux;

  assign w_tick = r_pwm_enable &&
                  ((PRESCALE == 1) || (r_presc == LP_LAST));
  assign w_clr = wr_strobe && (reg_addr == 2'd2) && wr_data[1];
  assign w_on_ld = (r_on > r_period) ? r_period : r_on;

  // Read-back mux, sampled into r_rd_data one clock after the strobe.
  always_comb begin
    w_rd_mux = '0;
    case (reg_addr)
      2'd0: w_rd_mux = 32'(r_period);
      2'd1: w_rd_mux = 32'(r_on);
      2'd2: w_rd_mux = {16'b0, 8'(PWM_UNIT), 6'b0, 1'b0, r_en};
      default: w_rd_mux = {16'b0, r_count};
    endcase
  end

  // Bus slave: shadow/CTRL writes, one-cycle ack and read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_period  <= '0;
      r_on      <= '0;
      r_en      <= 1'b0;
      r_ack     <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_ack     <= wr_strobe | rd_strobe;
      r_rd_data <= '0;
      if (wr_strobe) begin
        case (reg_addr)
          2'd0: r_period <= wr_data[WIDTH-1:0];
          2'd1: r_on     <= wr_data[WIDTH-1:0];
          2'd2: r_en     <= wr_data[0];
          default: ;
        endcase
      end else if (rd_strobe) begin
        r_rd_data <= w_rd_mux;
      end
    end
  end

  // Completed-period counter; an explicit clear beats a reload.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (w_clr) begin
      r_count <= '0;
    end else if (reload_times) begin
      r_count <= r_count + 16'd1;
    end
  end

  // Registered run enable and reload pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pwm_enable  <= 1'b0;
      r_period_done <= 1'b0;
    end else begin
      r_pwm_enable  <= r_en && (r_period != '0);
      r_period_done <= reload_times;
    end
  end

  // Prescaler restarts at each reload and only runs while enabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_presc <= '0;
    end else if (reload_times) begin
      r_presc <= '0;
    end else if (r_pwm_enable) begin
      r_presc <= (r_presc == LP_LAST) ? 16'd0 : r_presc + 16'd1;
    end
  end

  // Down-counters: reload wins, otherwise saturating decrement.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_t_on     <= '0;
      r_t_period <= '0;
    end else if (reload_times) begin
      r_t_on     <= w_on_ld;
      r_t_period <= r_period;
    end else begin
      if (dec_T_on && w_tick && (r_t_on != '0))
        r_t_on <= r_t_on - 1'b1;
      if (dec_T_period && w_tick && (r_t_period != '0))
        r_t_period <= r_t_period - 1'b1;
    end
  end

  assign rd_data       = r_rd_data;
  assign ack           = r_ack;
  assign pwm_enable    = r_pwm_enable;
  assign period_done   = r_period_done;
  assign T_on_zero     = (r_t_on == '0);
  assign T_period_zero = (r_t_period == '0);

endmodule

// File: tb/tb_pwm_timer_ctrl.sv
// tb_pwm_timer_ctrl: random bus/FSM stimulus against an arithmetic
// reference model of the timer controller.
module tb_pwm_timer_ctrl;

  localparam int P    = 3;
  localparam int UNIT = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_strobe = 1'b0;
  logic        rd_strobe = 1'b0;
  logic [1:0]  reg_addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic        ack;
  logic        dec_T_on = 1'b0;
  logic        dec_T_period = 1'b0;
  logic        reload_times = 1'b0;
  logic        pwm_enable;
  logic        T_on_zero;
  logic        T_period_zero;
  logic        period_done;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int m_period, m_on, m_count, m_enclk;
  int m_on_ld, m_on_dec, m_per_ld, m_per_dec;
  bit m_en, m_pen, m_done, m_ack;
  int m_rd;

  pwm_timer_ctrl #(.WIDTH(16), .PRESCALE(P), .PWM_UNIT(UNIT)) u_dut (
    .clk(clk), .reset(reset),
    .wr_strobe(wr_strobe), .rd_strobe(rd_strobe),
    .reg_addr(reg_addr), .wr_data(wr_data),
    .rd_data(rd_data), .ack(ack),
    .dec_T_on(dec_T_on), .dec_T_period(dec_T_period),
    .reload_times(reload_times),
    .pwm_enable(pwm_enable), .T_on_zero(T_on_zero),
    .T_period_zero(T_period_zero), .period_done(period_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_period = 0; m_on = 0; m_count = 0; m_enclk = 0;
    m_on_ld = 0; m_on_dec = 0; m_per_ld = 0; m_per_dec = 0;
    m_en = 0; m_pen = 0; m_done = 0; m_ack = 0; m_rd = 0;
  endtask

  task automatic check_all();
    chk("pwm_enable", 32'(pwm_enable), 32'(m_pen));
    chk("T_on_zero", 32'(T_on_zero), 32'(m_on_ld == m_on_dec));
    chk("T_period_zero", 32'(T_period_zero),
        32'(m_per_ld == m_per_dec));
    chk("period_done", 32'(period_done), 32'(m_done));
    chk("ack", 32'(ack), 32'(m_ack));
    chk("rd_data", rd_data, 32'(m_rd));
  endtask

  // One clock: drive, advance model on the edge, compare after it.
  task automatic step(input bit wr, input bit rd, input int a,
                      input int d, input bit don, input bit dper,
                      input bit rel);
    bit tick, npen;
    wr_strobe = wr; rd_strobe = rd; reg_addr = 2'(a);
    wr_data = 32'(d); dec_T_on = don; dec_T_period = dper;
    reload_times = rel;
    @(posedge clk);
    tick = m_pen && ((m_enclk % P) == P - 1);
    npen = m_en && (m_period != 0);
    m_ack = wr || rd;
    m_rd = 0;
    if (!wr && rd) begin
      case (a)
        0: m_rd = m_period;
        1: m_rd = m_on;
        2: m_rd = (UNIT << 8) | int'(m_en);
        default: m_rd = m_count;
      endcase
    end
    if (rel) begin
      m_per_ld = m_period;
      m_on_ld = (m_on < m_period) ? m_on : m_period;
      m_on_dec = 0; m_per_dec = 0; m_enclk = 0;
      m_count = (m_count + 1) % 65536;
    end else begin
      if (don && tick && m_on_ld > m_on_dec) m_on_dec++;
      if (dper && tick && m_per_ld > m_per_dec) m_per_dec++;
      if (m_pen) m_enclk++;
    end
    if (wr) begin
      case (a)
        0: m_period = d & 16'hFFFF;
        1: m_on = d & 16'hFFFF;
        2: begin
          m_en = d[0];
          if (d[1]) m_count = 0;
        end
        default: ;
      endcase
    end
    m_pen = npen;
    m_done = rel;
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rnd_step();
    int a, d;
    a = int'($urandom % 4);
    case (a)
      0: d = int'($urandom % 13);
      1: d = int'($urandom % 22);
      2: d = {($urandom % 10) == 0, ($urandom % 4) != 0};
      default: d = int'($urandom);
    endcase
    step(($urandom % 6) == 0, ($urandom % 6) == 0, a, d,
         ($urandom % 4) != 0, ($urandom % 4) != 0,
         ($urandom % 16) == 0);
  endtask

  initial begin
    m_reset();
    #12;
    check_all();
    reset = 1'b1;
    idle(2);

    // directed: clamp ON to PERIOD, then count down
    step(1, 0, 0, 10, 0, 0, 0);
    step(1, 0, 1, 20, 0, 0, 0);
    step(1, 0, 2, 1, 0, 0, 0);
    idle(2);
    step(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 36; i++) step(0, 0, 0, 0, 1, 1, 0);
    // write colliding with reload, then read-back
    step(1, 0, 0, 5, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0, 0);
    step(1, 1, 2, 1, 0, 0, 0);
    step(0, 1, 2, 0, 0, 0, 0);
    // PERIOD=0 blocks the run enable
    step(1, 0, 0, 0, 0, 0, 0);
    idle(3);

    for (int i = 0; i < 3000; i++) rnd_step();

    // reset during an active ON phase
    step(1, 0, 0, 9, 0, 0, 0);
    step(1, 0, 1, 6, 0, 0, 0);
    step(1, 0, 2, 1, 0, 0, 0);
    idle(2);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 1, 0);
    #2 reset = 1'b0;
    #1;
    m_reset();
    check_all();
    @(posedge clk);
    #1 reset = 1'b1;
    idle(4);

    // COUNT wrap from 0xFFFF to 0
    step(1, 0, 2, 2, 0, 0, 0);
    for (int i = 0; i < 65535; i++) step(0, 0, 0, 0, 0, 0, 1);
    step(0, 1, 3, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 1, 3, 0, 0, 0, 0);
    step(1, 0, 3, 7, 0, 0, 0);
    step(0, 1, 3, 0, 0, 0, 0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pwm_timer_ctrl.md
# pwm_timer_ctrl

Timer and configuration controller for one PWM channel. It holds the bus-programmable period, ON-time and enable settings and owns the ON and period down-counters. It drives the `pwm_enable`, `T_on_zero` and `T_period_zero` inputs of the PWM state machine and executes its `dec_T_on`, `dec_T_period` and `reload_times` commands. It sits between the register bus decoder and the per-channel PWM FSM; one instance exists per PWM unit.

## Interface
- `WIDTH`, 16: width of the period and ON counters and of their shadow registers.
- `PRESCALE`, 1: clocks per counter tick; 1 means a tick every clock. Legal range is 1..65535.
- `PWM_UNIT`, 0: channel index. It is reported in the read-back of the control register, bits [15:8].
- `clk`  in  1  system clock.
- `reset`  in  1  reset, asynchronous, active-low.
- `wr_strobe`  in  1  one-cycle register write request.
- `rd_strobe`  in  1  one-cycle register read request.
- `reg_addr`  in  2  register select: 0 = PERIOD, 1 = ON, 2 = CTRL, 3 = COUNT (read-only).
- `wr_data`  in  32  write data; the low `WIDTH` bits are used for PERIOD and ON.
- `rd_data`  out  32  read data, valid while `ack` is high.
- `ack`  out  1  one-cycle acknowledge for a read or a write.
- `dec_T_on`  in  1  request from the FSM to decrement the ON counter.
- `dec_T_period`  in  1  request from the FSM to decrement the period counter.
- `reload_times`  in  1  request from the FSM to load both counters from the shadow registers.
- `pwm_enable`  out  1  run enable to the FSM.
- `T_on_zero`  out  1  ON counter is 0.
- `T_period_zero`  out  1  period counter is 0.
- `period_done`  out  1  one-cycle pulse at each reload.

## Operation
- **Shadow registers:**
  - PERIOD and ON are written only through the bus. The counters never read them except on a reload.
  - A new PERIOD or ON value therefore takes effect at the next period boundary, with no glitch.
- **CTRL register:**
  - bit0 = enable; bit1 = clear COUNT (self-clearing, always reads 0).
  - Read-back is {16'b0, PWM_UNIT[7:0], 6'b0, 0, enable}.
- **COUNT register:** 16-bit count of completed periods. It increments on every `reload_times` and wraps from 0xFFFF to 0. Writes to address 3 are acknowledged and ignored.
- **Run enable:** `pwm_enable` = CTRL.enable && (PERIOD shadow != 0), registered.
- **Reload:** on `reload_times`, the period counter loads PERIOD.
  - The ON counter loads min(ON, PERIOD), so ON is clamped to PERIOD.
  - The prescaler resets to 0.
- **Prescaler:** counts 0..PRESCALE-1 while `pwm_enable` is high. `tick` is asserted when the prescaler equals PRESCALE-1, and always when PRESCALE = 1.
- **Decrement:** a counter decrements when its `dec_*` input is high, `tick` is high and the counter is nonzero. Counters saturate at 0 and never wrap.
- **Zero flags:** combinational compares of the counters.
- **Simultaneous events:**
  - A write in the same cycle as `reload_times`: the reload uses the old shadow value, and the new value applies from the following period.
  - `reload_times` together with `dec_*`: the reload wins.
  - `wr_strobe` together with `rd_strobe`: the write is performed; the read is dropped and `rd_data` = 0.
- **Disable mid-period:**
  - `pwm_enable` falls 1 clock after the CTRL write. The counters hold their values.
  - The FSM restarts through its reload path, so nothing stale is used.
- **Reset:** all registers and counters are 0.
  - `pwm_enable`, `ack`, `period_done` and `rd_data` are 0.
  - `T_on_zero` and `T_period_zero` are 1.

## Timing
- **Write:** strobe at cycle N; the register is updated and `ack` is high at N+1. `ack` is high for exactly one cycle.
- **Read:** strobe at N; `rd_data` and `ack` are valid at N+1. `rd_data` returns to 0 at N+2.
- **Enable:** a CTRL.enable write at N gives `pwm_enable` = 1 at N+2 (register write, then registered enable).
- **Reload:** `reload_times` at N gives counters loaded and `period_done` = 1 at N+1, and COUNT incremented at N+1.
- **Period length:** with PRESCALE = P, a loaded counter value V reaches 0 after V·P decrement-enabled clocks.

## Test plan
- **Basic PWM:** PERIOD=10, ON=4, enable, PRESCALE=1, driven by the PWM FSM → FSM `pwm` high for 4 clocks per period; `period_done` pulse every 13 clocks (10 + FSM overhead 3); COUNT increments each period.
- **Shadow update:** write ON=7 midway through a period → current period keeps 4 high clocks; next period has 7; no high pulse is shortened.
- **Clamp and zero:** ON=20 with PERIOD=10 → ON counter loads 10. PERIOD=0 with enable=1 → `pwm_enable` stays 0.
- **Prescaler:** PRESCALE=4, PERIOD=3, ON=1 → T_on_zero rises 4 clocks after the first `dec_T_on`; T_period_zero rises 12 clocks after it.
- **Collisions:** write PERIOD=5 in the same cycle as `reload_times` → counter loads the old value; `ack` at N+1. Simultaneous rd and wr → write done, `rd_data` = 0. COUNT at 0xFFFF plus one reload → 0.
- **Reset mid-run:** assert reset during the ON phase → all outputs take their reset values immediately; after release, `pwm_enable` stays 0 until CTRL is rewritten.
